// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage (MEM/WB latch, load filter,
// result select, RF write port and EX forward port).
// Optional feature macro: WB_RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter on o_retire_cnt; without it o_retire_cnt is tied to zero.
//
// Handshake: MEM side transfers on a rising edge when i_mem_valid && o_mem_ready
// && !i_flush. RF side retires the held entry on a rising edge when the entry is
// valid and i_rf_ready is high; the write itself is only offered (o_wb_we) when
// the entry actually writes a nonzero, aligned register. o_mem_ready never
// depends on i_mem_valid.
module wb_stage_pipe #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int LINK_REG  = 31
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic                 i_mem_lui,
  input  logic [BITS_SIZE-1:0] i_mem_extension,
  input  logic [BITS_SIZE-1:0] i_mem_dato,
  input  logic [1:0]           i_mem_addr_lo,
  input  logic [1:0]           i_mem_size,
  input  logic                 i_mem_zero_ext,
  input  logic                 i_mem_to_reg,
  input  logic [BITS_SIZE-1:0] i_mem_alu,
  input  logic                 i_mem_jal,
  input  logic [BITS_SIZE-1:0] i_mem_pc8,
  input  logic [BITS_REGS-1:0] i_mem_reg_dst,
  input  logic                 i_mem_reg_write,
  input  logic                 i_rf_ready,
  output logic                 o_wb_we,
  output logic [BITS_REGS-1:0] o_wb_addr,
  output logic [BITS_SIZE-1:0] o_wb_data,
  output logic                 o_fwd_valid,
  output logic [BITS_REGS-1:0] o_fwd_reg,
  output logic [BITS_SIZE-1:0] o_fwd_data,
  output logic                 o_misalign,
  output logic [31:0]          o_retire_cnt
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 reg_write_q;
  logic [BITS_REGS-1:0] addr_q;
  logic [BITS_SIZE-1:0] data_q;
  logic [BITS_SIZE-1:0] fwd_data_q;
  logic                 misalign_q;

  logic                 valid;
  logic                 accept;
  logic                 retire;
  logic                 writes_reg;

  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;
  logic [BITS_SIZE-1:0] filtered;
  logic [BITS_SIZE-1:0] nonlink_d;
  logic [BITS_SIZE-1:0] data_d;
  logic [BITS_REGS-1:0] addr_d;
  logic                 misalign_d;

  assign valid       = (state_q == ST_FULL);
  assign o_mem_ready = !valid || i_rf_ready;
  assign accept      = i_mem_valid && o_mem_ready && !i_flush;
  assign retire      = valid && i_rf_ready;

  // Load filter: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    byte_lane = 8'(i_mem_dato >> {i_mem_addr_lo, 3'b000});
    half_lane = 16'(i_mem_dato >> {i_mem_addr_lo[1], 4'b0000});
    filtered  = i_mem_dato;
    case (i_mem_size)
      2'b00:   filtered = i_mem_zero_ext ? {{(BITS_SIZE-8){1'b0}}, byte_lane}
                                         : {{(BITS_SIZE-8){byte_lane[7]}}, byte_lane};
      2'b01:   filtered = i_mem_zero_ext ? {{(BITS_SIZE-16){1'b0}}, half_lane}
                                         : {{(BITS_SIZE-16){half_lane[15]}}, half_lane};
      default: filtered = i_mem_dato;
    endcase
  end

  // Result/address select and misalignment detection for the incoming entry.
  always_comb begin
    nonlink_d  = i_mem_to_reg ? (i_mem_lui ? i_mem_extension : filtered) : i_mem_alu;
    data_d     = i_mem_jal ? i_mem_pc8 : nonlink_d;
    addr_d     = i_mem_jal ? BITS_REGS'(LINK_REG) : i_mem_reg_dst;
    misalign_d = i_mem_to_reg && !i_mem_lui &&
                 (((i_mem_size == 2'b01) && i_mem_addr_lo[0]) ||
                  (i_mem_size[1] && (i_mem_addr_lo != 2'b00)));
  end

  // Holding-register state: flush wins over everything, accept refills,
  // a lone retire drains.
  always_comb begin
    state_d = state_q;
    if (i_flush)     state_d = ST_EMPTY;
    else if (accept) state_d = ST_FULL;
    else if (retire) state_d = ST_EMPTY;
  end

  // State and held fields; fields only load on a real accept.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_EMPTY;
      reg_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      fwd_data_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        reg_write_q <= i_mem_reg_write;
        addr_q      <= addr_d;
        data_q      <= data_d;
        fwd_data_q  <= nonlink_d;
        misalign_q  <= misalign_d;
      end
    end
  end

  assign writes_reg  = valid && reg_write_q && (addr_q != '0) && !misalign_q;
  assign o_wb_we     = writes_reg && i_rf_ready;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_fwd_valid = writes_reg;
  assign o_fwd_reg   = addr_q;
  assign o_fwd_data  = fwd_data_q;
  assign o_misalign  = valid && misalign_q;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  // Retired-instruction counter; every retire counts, wraps naturally.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 32'd1;
  end

  assign o_retire_cnt = cnt_q;
`else
  assign o_retire_cnt = 32'd0;
`endif

endmodule
